seq1011_scan_ctrl: RTL and testbench



---
 rtl/seq1011_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seq1011_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq1011_scan_ctrl.sv
// Word-to-serial scan controller driving one overlapping "1011" Mealy detector.
// Optional macro SEQ1011_CARRY_EN: detector state carries across word boundaries.
//
// state    | meaning
// S_IDLE   | ready for a new word
// S_SHIFT  | feeding shift register MSB into the detector, one bit per clock
// S_REPORT | per-word count presented, waiting for out_ready
module seq1011_scan_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 4,
    parameter int TOT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_any,
    output logic             busy,
    output logic [TOT_W-1:0] total
);

    localparam int IDX_W = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_REPORT} state_t;
    typedef enum logic [1:0] {D_A, D_B, D_C, D_D} det_t;

    state_t           r_state;
    det_t             r_det;
    logic [W-1:0]     r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;
    logic [TOT_W-1:0] r_total;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_any;

    logic             w_bit;
    logic             w_match;
    det_t             w_det_nxt;
    logic [CNT_W-1:0] w_count_inc;

    assign w_bit       = r_shift[W-1];
    assign w_match     = (r_state == S_SHIFT) && (r_det == D_D) && w_bit;
    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

    always_comb begin
        w_det_nxt = D_A;
        case (r_det)
            D_A: w_det_nxt = w_bit ? D_B : D_A;
            D_B: w_det_nxt = w_bit ? D_B : D_C;
            D_C: w_det_nxt = w_bit ? D_D : D_A;
            D_D: w_det_nxt = w_bit ? D_B : D_C;
            default: w_det_nxt = D_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_det       <= D_A;
            r_shift     <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_total     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_any       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift    <= in_data;
                        r_idx      <= IDX_W'(W - 1);
                        r_count    <= '0;
                        r_any      <= 1'b0;
`ifdef SEQ1011_CARRY_EN
                        r_det      <= r_det;
`else
                        r_det      <= D_A;
`endif
                        r_state    <= S_SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_det   <= w_det_nxt;
                    r_shift <= r_shift << 1;
                    if (w_match) begin
                        r_count <= w_count_inc;
                        r_any   <= 1'b1;
                        r_total <= r_total + TOT_W'(1);
                    end
                    // bit 0 is consumed on this edge, so the report starts right after it
                    if (r_idx == '0) begin
                        r_state     <= S_REPORT;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                S_REPORT: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_count;
    assign out_any   = r_any;
    assign busy      = r_busy;
    assign total     = r_total;

endmodule

// File: tb/tb_seq1011_scan_ctrl.sv
// Scoreboard bench for seq1011_scan_ctrl; a second instance with CNT_W=1 checks saturation.
module tb_seq1011_scan_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_data = '0;

    logic         in_ready, out_valid, out_any, busy;
    logic [3:0]   out_count;
    logic [15:0]  total;
    logic         b_in_ready, b_out_valid, b_out_any, b_busy;
    logic [0:0]   b_out_count;
    logic [15:0]  b_total;

    seq1011_scan_ctrl #(.W(W), .CNT_W(4), .TOT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_any(out_any), .busy(busy), .total(total)
    );

    seq1011_scan_ctrl #(.W(W), .CNT_W(1), .TOT_W(16)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_count(b_out_count),
        .out_any(b_out_any), .busy(b_busy), .total(b_total)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {int cnt; int cnt1; int tot;} exp_t;
    exp_t sb[$];

    logic [3:0] m_hist;
    int         m_nbits;
    int         m_total;

    // sliding window over the bit stream; every position ending in 1011 is a hit
    task automatic model_push(input logic [W-1:0] d);
        int   n;
        exp_t e;
        n = 0;
`ifndef SEQ1011_CARRY_EN
        m_hist  = '0;
        m_nbits = 0;
`endif
        for (int i = W - 1; i >= 0; i--) begin
            m_hist = {m_hist[2:0], d[i]};
            m_nbits++;
            if (m_nbits >= 4 && m_hist == 4'b1011) n++;
        end
        m_total = (m_total + n) & 32'hFFFF;
        e.cnt  = (n > 15) ? 15 : n;
        e.cnt1 = (n > 1) ? 1 : n;
        e.tot  = m_total;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_hist = '0;
        m_nbits = 0;
        m_total = 0;
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_any"}, out_any, 0);
        chk({tag, "_total"}, total, 0);
    endtask

    task automatic accept_word(input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 1, 0);
        @(posedge clk);
        model_push(d);
        #1 in_valid = 1'b0;
    endtask

    // returns at the first negedge that sees out_valid
    task automatic wait_report();
        int   lat;
        logic bad;
        exp_t e;
        lat = 0;
        bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && (in_ready || !busy)) bad = 1'b1;
        end while (!out_valid && lat < 100);
        chk("latency", lat, W + 1);
        chk("shift_in_ready_low", bad, 0);
        chk("report_in_ready", in_ready, 0);
        chk("report_busy", busy, 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("count", out_count, e.cnt);
            chk("any", out_any, (e.cnt != 0));
            chk("total", total, e.tot);
            chk("count_cnt1", b_out_count, e.cnt1);
            chk("total_cnt1", b_total, e.tot);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c0;
        logic       bad;

        m_hist = '0;
        m_nbits = 0;
        m_total = 0;

        // 1: reset state, single word
        do_reset();
        check_idle("rst1");
        chk("rst1_count", out_count, 0);
        accept_word(8'hB6);
        wait_report();

        // 2: back-to-back words
        do_reset();
        accept_word(8'hBB); wait_report();
        accept_word(8'h00); wait_report();
        accept_word(8'hFF); wait_report();

        // 3: pattern spanning a word boundary
        do_reset();
        accept_word(8'h05); wait_report();
        accept_word(8'h80); wait_report();

        // 5: backpressure with the next word already offered
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        accept_word(8'hBB);
        wait_report();
        in_valid = 1'b1;
        in_data = 8'hB6;
        c0 = out_count;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_count !== c0 || !out_valid || in_ready || !busy) bad = 1'b1;
        end
        chk("bp_hold", bad, 0);
        chk("bp_count", out_count, 2);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        chk("bp_release_out_valid", out_valid, 0);
        @(posedge clk);
        model_push(8'hB6);
        #1 in_valid = 1'b0;
        wait_report();

        // 6: reset in the middle of a word
        do_reset();
        accept_word(8'hBB);
        repeat (3) @(posedge clk);
        do_reset();
        check_idle("rst6");
        accept_word(8'hB6);
        wait_report();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
